load_unit_ctrl: RTL and testbench
=================================

Name: load_unit_ctrl

Overview:
Sequencing controller for RV32I loads. Takes one decoded load (rs1 value, 12-bit immediate, rd, 3-bit load_control), computes the effective address and issues one word-aligned read on the data-memory port. It waits for the response, then extracts and sign- or zero-extends the addressed byte, halfword or word and presents it for register-file writeback. It sits between the load decoder and the data-memory interface and handles one load at a time.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in WAIT before the load is abandoned with an error pulse. Legal range 1..65535.

Ports:
clk  in  1  system clock; all logic updates on the rising edge
reset  in  1  synchronous, active-high reset
ld_valid  in  1  decoded load presented
ld_ready  out  1  controller can accept a load (high only in IDLE)
rs1_data  in  32  base register value
imm  in  12  signed offset
rd  in  5  destination register
load_control  in  3  LB/LH/LW/LBU/LHU/LD_NOP encoding from processor_defines.sv
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts the request
mem_addr  out  32  word-aligned address: {eff_addr[31:2], 2'b00}
mem_rsp_valid  in  1  read data valid
mem_rdata  in  32  read word, little-endian
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  32  extended load result
misaligned  out  1  one-cycle pulse: misaligned load dropped
timeout  out  1  one-cycle pulse: memory response never arrived
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state is IDLE. ld_ready=1. mem_req_valid, wb_valid, misaligned, timeout and busy are 0. mem_addr, wb_rd and wb_data are 0. The timeout counter is 0. Reset overrides all states and abandons any in-flight load; a response that arrives later is ignored.
- Effective address: eff_addr = rs1_data + sign-extended imm, 32-bit, wrapping modulo 2^32. The address, rd and load_control are registered on accept.
- IDLE: a load is accepted when ld_valid and ld_ready are both high.
  - LD_NOP, or any undefined encoding: dropped, no output activity, stay in IDLE.
  - Misaligned: LH/LHU with eff_addr[0]=1, or LW with eff_addr[1:0]!=0. Pulse misaligned in the next cycle, issue no request, return to IDLE.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1 and mem_addr is held stable until mem_req_ready. On a cycle with valid and ready both high, go to WAIT and clear the counter. mem_rsp_valid is ignored while in REQ.
- WAIT: the counter increments each cycle.
  - On mem_rsp_valid, capture mem_rdata and go to WB.
  - If the counter reaches TIMEOUT_CYCLES without a response, pulse timeout for one cycle, write nothing back, go to IDLE.
  - If the response and the timeout occur in the same cycle, the response wins.
- WB: wb_valid=1 for exactly one cycle, then go to IDLE. If rd==0, wb_valid stays 0, but the state still passes through WB. wb_rd and wb_data hold their values until the next writeback.
- Data extraction (addr[1:0] is the low two bits of eff_addr):
  - LB/LBU: take the byte at mem_rdata[8*addr[1:0] +: 8].
  - LH/LHU: take the halfword at mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend the selected data; LBU/LHU zero-extend it; LW passes the word through.
- Latency: accept at edge T, request visible in cycle T+1. With mem_req_ready=1 and the response one cycle after the request, wb_valid is high in cycle T+3. Back-to-back loads: the next accept can happen in the cycle after WB.
- ld_ready=0 in every state except IDLE. The upstream stage holds its inputs until they are accepted.

Test Plan:
- LW: rs1=0x1000, imm=0x004, rd=5, memory returns 0xDEADBEEF one cycle after request -> mem_addr=0x00001004, wb_valid in cycle T+3, wb_rd=5, wb_data=0xDEADBEEF.
- LB/LBU: rs1=0x2000, imm=0xFFF (-1), memory word 0x80112233 -> mem_addr=0x00001FFC, lane 3. LB gives wb_data=0xFFFFFF80; LBU gives 0x00000080.
- LH/LHU: eff_addr=0x3002, word 0x9ABC1234 -> LH gives 0xFFFF9ABC, LHU gives 0x00009ABC. A separate LW at eff_addr=0x3002 -> misaligned pulses once, mem_req_valid never rises, ld_ready returns high the next cycle.
- Request backpressure and timeout: hold mem_req_ready=0 for 4 cycles -> mem_req_valid and mem_addr stay stable throughout. Then withhold the response with TIMEOUT_CYCLES=8 -> timeout pulses once after 8 WAIT cycles, no wb_valid.
- rd=0 LW -> memory request issued, wb_valid stays 0. LD_NOP -> no request and no pulses, busy stays 0.
- Assert reset in WAIT, then deliver mem_rsp_valid -> all outputs at reset values, no wb_valid. A new LW afterwards completes normally.

Source files
------------

// File: rtl/load_unit_ctrl_if.sv
// Data-memory read port between the load controller and memory.
// Request handshake plus a single-beat read response.
interface load_unit_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid,
    output mem_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rdata
  );
endinterface

// File: rtl/load_unit_ctrl.sv
// RV32I load sequencer: address calc, one aligned read, extract/extend.
// Handles one load at a time; abandons it after TIMEOUT_CYCLES.
module load_unit_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] rs1_data,
  input  logic [11:0] imm,
  input  logic [4:0]  rd,
  input  logic [2:0]  load_control,
  load_unit_ctrl_if.master mem,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        timeout,
  output logic        busy
);

  localparam logic [2:0] LC_LB  = 3'b000;
  localparam logic [2:0] LC_LH  = 3'b001;
  localparam logic [2:0] LC_LW  = 3'b010;
  localparam logic [2:0] LC_LBU = 3'b100;
  localparam logic [2:0] LC_LHU = 3'b101;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  lc_q, lc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;

  logic [31:0] eff_addr;
  logic        lc_def;
  logic        lc_mis;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;

  always_comb begin
    eff_addr = rs1_data + {{20{imm[11]}}, imm};
    lc_def   = 1'b0;
    lc_mis   = 1'b0;
    unique case (1'b1)
      (load_control == LC_LB),
      (load_control == LC_LBU): lc_def = 1'b1;
      (load_control == LC_LH),
      (load_control == LC_LHU): begin
        lc_def = 1'b1;
        lc_mis = eff_addr[0];
      end
      (load_control == LC_LW): begin
        lc_def = 1'b1;
        lc_mis = |eff_addr[1:0];
      end
      default: lc_def = 1'b0;
    endcase
  end

  // Lane select uses the byte offset kept from the effective address
  always_comb begin
    sel_b = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    sel_h = mem.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (1'b1)
      (lc_q == LC_LB):  ext = {{24{sel_b[7]}}, sel_b};
      (lc_q == LC_LBU): ext = {24'd0, sel_b};
      (lc_q == LC_LH):  ext = {{16{sel_h[15]}}, sel_h};
      (lc_q == LC_LHU): ext = {16'd0, sel_h};
      default:          ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    lc_d      = lc_q;
    cnt_d     = cnt_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    mis_d     = 1'b0;
    to_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_valid && lc_def) begin
          if (lc_mis) begin
            mis_d = 1'b1;
          end else begin
            state_d = S_REQ;
            addr_d  = eff_addr;
            rd_d    = rd;
            lc_d    = load_control;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response in the last waiting cycle still completes the load
        if (mem.mem_rsp_valid) begin
          state_d = S_WB;
          if (rd_q != 5'd0) begin
            wb_rd_d   = rd_q;
            wb_data_d = ext;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WB: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_q      <= '0;
      lc_q      <= '0;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      lc_q      <= lc_d;
      cnt_q     <= cnt_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
    end
  end

  assign ld_ready          = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign mem.mem_req_valid = (state_q == S_REQ);
  assign mem.mem_addr      = {addr_q[31:2], 2'b00};
  assign wb_valid          = (state_q == S_WB) && (rd_q != 5'd0);
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign misaligned        = mis_q;
  assign timeout           = to_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Bench for load_unit_ctrl: vector table, writeback scoreboard,
// and hand sequences for misalign, nop, timeout and reset-in-wait.
module tb_load_unit_ctrl;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] NOP = 3'b111;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] rs1_data;
  logic [11:0] imm;
  logic [4:0]  rd;
  logic [2:0]  load_control;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        timeout;
  logic        busy;

  load_unit_ctrl_if mif();

  load_unit_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .rs1_data     (rs1_data),
    .imm          (imm),
    .rd           (rd),
    .load_control (load_control),
    .mem          (mif),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misaligned   (misaligned),
    .timeout      (timeout),
    .busy         (busy)
  );

  typedef struct {
    logic [2:0]  lc;
    logic [31:0] rs1;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [31:0] word;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;
  int   mis_cnt = 0;
  int   to_cnt = 0;
  int   req_cnt = 0;
  logic req_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard and pulse monitors
  always @(negedge clk) begin
    exp_t e;
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd %0d data %h expected none",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("sb_wb_data", wb_data, e.data);
      end
    end
    if (misaligned) mis_cnt++;
    if (timeout) to_cnt++;
    if (mif.mem_req_valid && !req_prev) req_cnt++;
    req_prev = mif.mem_req_valid;
  end

  task automatic issue(input logic [2:0] lc, input logic [31:0] r1,
                       input logic [11:0] im, input logic [4:0] d);
    int n = 0;
    while (!ld_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ld_ready_wait", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    rs1_data = r1;
    imm = im;
    rd = d;
    load_control = lc;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    if (v.rd != 5'd0) exp_q.push_back('{v.rd, v.data});
    issue(v.lc, v.rs1, v.imm, v.rd);
    chk("req_valid", {31'd0, mif.mem_req_valid}, 32'd1);
    chk("mem_addr", mif.mem_addr, v.addr);
    chk("ld_ready_busy", {31'd0, ld_ready}, 32'd0);
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, mif.mem_req_valid}, 32'd1);
      chk("stall_addr", mif.mem_addr, v.addr);
    end
    mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.mem_req_ready = 1'b0;
    chk("req_dropped", {31'd0, mif.mem_req_valid}, 32'd0);
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rdata = v.word;
    @(posedge clk); #1;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rdata = 32'd0;
    chk("wb_valid_t3", {31'd0, wb_valid}, {31'd0, v.rd != 5'd0});
  endtask

  initial begin
    int base;
    ld_valid = 1'b0;
    rs1_data = '0;
    imm = '0;
    rd = '0;
    load_control = NOP;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, mif.mem_req_valid}, 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_wb", {wb_valid, misaligned, timeout, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    reset = 1'b0;

    vecs[0] = '{LW,  32'h1000, 12'h004, 5'd5,  32'hDEADBEEF,
                32'h1004, 32'hDEADBEEF, 0};
    vecs[1] = '{LB,  32'h2000, 12'hFFF, 5'd6,  32'h80112233,
                32'h1FFC, 32'hFFFFFF80, 0};
    vecs[2] = '{LBU, 32'h2000, 12'hFFF, 5'd7,  32'h80112233,
                32'h1FFC, 32'h00000080, 0};
    vecs[3] = '{LH,  32'h3004, 12'hFFE, 5'd8,  32'h9ABC1234,
                32'h3000, 32'hFFFF9ABC, 0};
    vecs[4] = '{LHU, 32'h3000, 12'h002, 5'd9,  32'h9ABC1234,
                32'h3000, 32'h00009ABC, 0};
    vecs[5] = '{LB,  32'h1000, 12'h001, 5'd10, 32'h80112233,
                32'h1000, 32'h00000022, 0};
    vecs[6] = '{LHU, 32'h3000, 12'h000, 5'd11, 32'h9ABC8234,
                32'h3000, 32'h00008234, 0};
    vecs[7] = '{LW,  32'hFFFFFFFC, 12'h008, 5'd12, 32'hCAFEF00D,
                32'h0004, 32'hCAFEF00D, 4};
    vecs[8] = '{LW,  32'h4000, 12'h000, 5'd0,  32'h11111111,
                32'h4000, 32'h0, 0};
    for (int i = 0; i < 9; i++) run_load(vecs[i]);
    chk("hold_wb_rd", {27'd0, wb_rd}, 32'd12);
    chk("hold_wb_data", wb_data, 32'hCAFEF00D);

    // Misaligned LW and LH: pulse once, no request
    base = req_cnt;
    issue(LW, 32'h3000, 12'h002, 5'd5);
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_noreq", {31'd0, mif.mem_req_valid}, 32'd0);
    chk("mis_ready", {31'd0, ld_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mis_once", {31'd0, misaligned}, 32'd0);
    issue(LH, 32'h3001, 12'h000, 5'd5);
    chk("mis_lh", {31'd0, misaligned}, 32'd1);
    @(posedge clk); #1;
    chk("mis_cnt", mis_cnt, 32'd2);
    chk("mis_req_cnt", req_cnt, base);

    // LD_NOP and an undefined encoding are silently dropped
    issue(NOP, 32'h1000, 12'h000, 5'd5);
    issue(3'b110, 32'h1000, 12'h000, 5'd5);
    for (int i = 0; i < 3; i++) begin
      chk("nop_quiet", {busy, mif.mem_req_valid, misaligned, timeout},
          32'd0);
      @(posedge clk); #1;
    end
    chk("nop_req_cnt", req_cnt, base);

    // Backpressure then timeout with no response
    issue(LW, 32'h1000, 12'h008, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, mif.mem_req_valid}, 32'd1);
      chk("bp_addr", mif.mem_addr, 32'h1008);
      @(posedge clk); #1;
    end
    mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.mem_req_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("to_early", {busy, timeout}, 32'd2);
    @(posedge clk); #1;
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("to_once", to_cnt, 32'd1);

    // Reset while waiting; late response must be ignored
    issue(LW, 32'h5000, 12'h000, 5'd13);
    mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.mem_req_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rw_ready", {31'd0, ld_ready}, 32'd1);
    chk("rw_addr", mif.mem_addr, 32'd0);
    chk("rw_wb", {busy, wb_valid, wb_rd}, 32'd0);
    chk("rw_data", wb_data, 32'd0);
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    mif.mem_rsp_valid = 1'b0;
    chk("rw_ignored", {busy, wb_valid, wb_rd}, 32'd0);
    chk("rw_data_kept", wb_data, 32'd0);
    run_load('{LW, 32'h6000, 12'h010, 5'd14, 32'h12345678,
               32'h6010, 32'h12345678, 0});

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
